// File: rtl/lcd_pkg.sv
// Constants and types shared by the LCD pixel feeder and the panel timing generator.
package lcd_pkg;

    localparam int ACTIVE_HOR    = 480;
    localparam int ACTIVE_VER    = 272;
    localparam int PIX_PER_FRAME = ACTIVE_HOR * ACTIVE_VER;
    localparam int PIX_W         = 22;

    typedef enum logic [1:0] {
        RESYNC     = 2'd0,
        WAIT_FRAME = 2'd1,
        STREAM     = 2'd2
    } feed_state_e;

endpackage

// File: rtl/lcd_pixel_fifo.sv
// Show-ahead FIFO: the oldest entry is always visible on head while not empty.
module lcd_pixel_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lcd_pixel_feeder.sv
// Buffers an RGB pixel stream and feeds one pixel per DE slot, locking stream frames
// to panel frames; DE/syncs/pixel leave through one register stage together.
//
// state      | meaning
// RESYNC     | drop non-SOF heads until a frame start sits at the FIFO head
// WAIT_FRAME | SOF held at head; arm on vsync low, start on first DE after that
// STREAM     | pop one pixel per DE slot, fill colour when starved
module lcd_pixel_feeder #(
    parameter int               DEPTH      = 16,
    parameter int               PIX_W      = lcd_pkg::PIX_W,
    parameter logic [PIX_W-1:0] FILL_COLOR = '0,
    parameter int               H_ACTIVE   = lcd_pkg::ACTIVE_HOR,
    parameter int               V_ACTIVE   = lcd_pkg::ACTIVE_VER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
    input  logic             s_sof,
    input  logic             de_in,
    input  logic             hsync_in,
    input  logic             vsync_in,
    output logic             de_out,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic [PIX_W-1:0] pix_out,
    output logic             underflow,
    output logic             sync_err,
    output logic [15:0]      underflow_cnt
);

    import lcd_pkg::*;

    localparam logic [1:0]  ST_RESYNC     = RESYNC;
    localparam logic [1:0]  ST_WAIT_FRAME = WAIT_FRAME;
    localparam logic [1:0]  ST_STREAM     = STREAM;
    localparam logic [16:0] LAST_PIX      = 17'(H_ACTIVE * V_ACTIVE - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             armed;
    logic             armed_nxt;
    logic [16:0]      pix_cnt;
    logic [16:0]      pix_cnt_nxt;
    logic             rdy_en;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [PIX_W:0]   fifo_head;
    logic             head_sof;
    logic [PIX_W-1:0] head_pix;
    logic             stream_slot;
    logic [PIX_W-1:0] pix_nxt;
    logic             underflow_nxt;
    logic             sync_err_nxt;
    logic [15:0]      underflow_cnt_nxt;

    // rdy_en keeps s_ready low until the first edge after reset is released.
    assign s_ready   = rdy_en && !fifo_full;
    assign fifo_push = s_valid && s_ready;
    assign head_sof  = fifo_head[PIX_W];
    assign head_pix  = fifo_head[PIX_W-1:0];

    lcd_pixel_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PIX_W + 1)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   ({s_sof, s_data}),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_comb begin
        state_nxt         = state;
        armed_nxt         = armed;
        pix_cnt_nxt       = pix_cnt;
        fifo_pop          = 1'b0;
        stream_slot       = 1'b0;
        pix_nxt           = FILL_COLOR;
        underflow_nxt     = 1'b0;
        sync_err_nxt      = 1'b0;
        underflow_cnt_nxt = underflow_cnt;

        case (state)
            ST_RESYNC: begin
                armed_nxt = 1'b0;
                if (!fifo_empty) begin
                    if (head_sof) begin
                        state_nxt = ST_WAIT_FRAME;
                    end else begin
                        fifo_pop = 1'b1;
                    end
                end
            end
            ST_WAIT_FRAME: begin
                if (!vsync_in) begin
                    armed_nxt = 1'b1;
                end
                if (de_in && armed) begin
                    state_nxt   = ST_STREAM;
                    stream_slot = 1'b1;
                end
            end
            ST_STREAM: begin
                stream_slot = de_in;
            end
            default: begin
                state_nxt = ST_RESYNC;
            end
        endcase

        // The entry slot from WAIT_FRAME shares this path, so pixel 0 pops there.
        if (stream_slot) begin
            if (!fifo_empty && head_sof && (pix_cnt != '0)) begin
                sync_err_nxt = 1'b1;
                state_nxt    = ST_WAIT_FRAME;
                armed_nxt    = 1'b0;
                pix_cnt_nxt  = '0;
            end else begin
                if (fifo_empty) begin
                    underflow_nxt = 1'b1;
                    if (underflow_cnt != 16'hFFFF) begin
                        underflow_cnt_nxt = underflow_cnt + 16'd1;
                    end
                end else begin
                    fifo_pop = 1'b1;
                    pix_nxt  = head_pix;
                end
                if (pix_cnt == LAST_PIX) begin
                    pix_cnt_nxt = '0;
                    state_nxt   = ST_RESYNC;
                end else begin
                    pix_cnt_nxt = pix_cnt + 17'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_RESYNC;
            armed         <= 1'b0;
            pix_cnt       <= '0;
            rdy_en        <= 1'b0;
            de_out        <= 1'b0;
            hsync_out     <= 1'b1;
            vsync_out     <= 1'b1;
            pix_out       <= FILL_COLOR;
            underflow     <= 1'b0;
            sync_err      <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            state         <= state_nxt;
            armed         <= armed_nxt;
            pix_cnt       <= pix_cnt_nxt;
            rdy_en        <= 1'b1;
            de_out        <= de_in;
            hsync_out     <= hsync_in;
            vsync_out     <= vsync_in;
            pix_out       <= pix_nxt;
            underflow     <= underflow_nxt;
            sync_err      <= sync_err_nxt;
            underflow_cnt <= underflow_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_lcd_pixel_feeder.sv
// Scoreboard bench for lcd_pixel_feeder on a shrunken 8x4 panel with directed frames.
module tb_lcd_pixel_feeder;

    localparam int              DEPTH = 16;
    localparam int              PW    = 22;
    localparam int              H     = 8;
    localparam int              V     = 4;
    localparam int              HB    = 24;
    localparam int              NPIX  = H * V;
    localparam logic [PW-1:0]   FILL  = 22'h3F0F0;

    typedef struct packed {
        logic [PW-1:0] pix;
        logic          uf;
        logic          serr;
    } exp_t;

    typedef struct packed {
        logic          sof;
        logic [PW-1:0] d;
    } word_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [PW-1:0] s_data;
    logic          s_sof;
    logic          de_in;
    logic          hsync_in;
    logic          vsync_in;
    logic          de_out;
    logic          hsync_out;
    logic          vsync_out;
    logic [PW-1:0] pix_out;
    logic          underflow;
    logic          sync_err;
    logic [15:0]   underflow_cnt;

    exp_t  sb_q[$];
    word_t src_q[$];
    word_t pend_q[$];
    exp_t  plan[NPIX];
    int    errors = 0;
    int    checks = 0;
    int    acc_cnt = 0;
    bit    mon_en = 1'b0;
    bit    hist_ok = 1'b0;
    logic  p_de, p_hs, p_vs;
    exp_t  mon_e;
    logic  r;

    lcd_pixel_feeder #(
        .DEPTH      (DEPTH),
        .PIX_W      (PW),
        .FILL_COLOR (FILL),
        .H_ACTIVE   (H),
        .V_ACTIVE   (V)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .s_sof         (s_sof),
        .de_in         (de_in),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
        .de_out        (de_out),
        .hsync_out     (hsync_out),
        .vsync_out     (vsync_out),
        .pix_out       (pix_out),
        .underflow     (underflow),
        .sync_err      (sync_err),
        .underflow_cnt (underflow_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: outputs must echo last cycle's inputs; each de_out pops one expectation.
    always @(negedge clk) begin
        if (!mon_en) begin
            hist_ok = 1'b0;
        end else begin
            if (hist_ok) begin
                check("sync_align", 32'({de_out, hsync_out, vsync_out}), 32'({p_de, p_hs, p_vs}));
                if (de_out) begin
                    if (sb_q.size() == 0) begin
                        check("sb_underrun", 32'(1), 32'(0));
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("pix", 32'(pix_out), 32'(mon_e.pix));
                        check("underflow", 32'(underflow), 32'(mon_e.uf));
                        check("sync_err", 32'(sync_err), 32'(mon_e.serr));
                    end
                end else begin
                    check("idle_out", 32'({pix_out, underflow, sync_err}), 32'({FILL, 2'b00}));
                end
            end
            p_de    = de_in;
            p_hs    = hsync_in;
            p_vs    = vsync_in;
            hist_ok = 1'b1;
        end
    end

    // One clock cycle of stimulus; the source head is consumed only if accepted.
    task automatic step(input logic de, input logic hs, input logic vs, output logic rdy);
        logic acc;
        de_in    = de;
        hsync_in = hs;
        vsync_in = vs;
        if (src_q.size() > 0) begin
            s_valid = 1'b1;
            s_sof   = src_q[0].sof;
            s_data  = src_q[0].d;
        end else begin
            s_valid = 1'b0;
            s_sof   = 1'b0;
            s_data  = '0;
        end
        @(negedge clk);
        rdy = s_ready;
        acc = s_valid && s_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            void'(src_q.pop_front());
            acc_cnt++;
        end
    endtask

    task automatic load_words(input int base, input int k0, input int k1, input bit to_pend);
        word_t w;
        for (int k = k0; k <= k1; k++) begin
            w.sof = (k == 0);
            w.d   = PW'(base + k);
            if (to_pend) pend_q.push_back(w);
            else         src_q.push_back(w);
        end
    endtask

    task automatic load_junk(input int base, input int n, input bit to_pend);
        word_t w;
        for (int k = 0; k < n; k++) begin
            w.sof = 1'b0;
            w.d   = PW'(base + k);
            if (to_pend) pend_q.push_back(w);
            else         src_q.push_back(w);
        end
    endtask

    task automatic plan_fill(input int s0, input int s1, input bit uf);
        for (int s = s0; s <= s1; s++) plan[s] = '{pix: FILL, uf: uf, serr: 1'b0};
    endtask

    task automatic plan_run(input int s0, input int s1, input int v0);
        for (int s = s0; s <= s1; s++) plan[s] = '{pix: PW'(v0 + s - s0), uf: 1'b0, serr: 1'b0};
    endtask

    // Panel frame: vsync-low line, blank line, then V active lines of HB blank + H DE cycles.
    task automatic panel_frame(input int abort_slot, input int inject_slot, input bit chk_full);
        int   slot;
        bit   done;
        logic de, hs, vs, rdy;
        slot = 0;
        done = 1'b0;
        for (int ln = 0; ln < V + 2 && !done; ln++) begin
            for (int c = 0; c < HB + H && !done; c++) begin
                de = (ln >= 2) && (c >= HB);
                hs = (c >= 2);
                vs = (ln != 0);
                if (de) begin
                    if (slot == inject_slot) begin
                        foreach (pend_q[i]) src_q.push_back(pend_q[i]);
                        pend_q.delete();
                    end
                    sb_q.push_back(plan[slot]);
                end
                step(de, hs, vs, rdy);
                if (de) begin
                    if (chk_full && slot == 0) check("ready_full_pop", 32'(rdy), 32'(0));
                    if (chk_full && slot == 1) check("ready_after_pop", 32'(rdy), 32'(1));
                    if (slot == abort_slot) done = 1'b1;
                    slot++;
                end
            end
        end
    endtask

    task automatic reset_dut();
        mon_en   = 1'b0;
        rst      = 1'b1;
        de_in    = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        s_valid  = 1'b0;
        s_sof    = 1'b0;
        s_data   = '0;
        src_q.delete();
        pend_q.delete();
        sb_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) step(1'b0, 1'b1, 1'b1, r);
        mon_en = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        // Normal frames, then an idle frame with nothing buffered.
        reset_dut();
        check("rst_cnt", 32'(underflow_cnt), 32'(0));
        load_words(0, 0, NPIX - 1, 1'b0);
        load_words(0, 0, NPIX - 1, 1'b0);
        plan_run(0, NPIX - 1, 0);
        panel_frame(-1, -1, 1'b0);
        panel_frame(-1, -1, 1'b0);
        plan_fill(0, NPIX - 1, 1'b0);
        panel_frame(-1, -1, 1'b0);
        check("normal_uf_cnt", 32'(underflow_cnt), 32'(0));

        // Lock-in: 100 non-SOF words then a frame, injected as the panel frame's DE starts.
        reset_dut();
        load_junk(22'h500, 100, 1'b1);
        load_words(22'h1000, 0, NPIX - 1, 1'b1);
        plan_fill(0, NPIX - 1, 1'b0);
        panel_frame(-1, 0, 1'b0);
        plan_run(0, NPIX - 1, 22'h1000);
        panel_frame(-1, -1, 1'b0);
        check("lock_uf_cnt", 32'(underflow_cnt), 32'(0));

        // Starvation: only pixels 0..9 buffered, rest arrive in slot 14 -> slots 10..14 starve.
        reset_dut();
        load_words(0, 0, 9, 1'b0);
        load_words(0, 10, NPIX - 1, 1'b1);
        plan_run(0, 9, 0);
        plan_fill(10, 14, 1'b1);
        plan_run(15, NPIX - 1, 10);
        panel_frame(-1, 14, 1'b0);
        check("starve_uf_cnt", 32'(underflow_cnt), 32'(5));

        // Early SOF at pixel 10: rest of frame is fill, new frame starts next panel frame.
        reset_dut();
        load_words(22'h100, 0, 9, 1'b0);
        load_words(22'h2000, 0, NPIX - 1, 1'b0);
        plan_run(0, 9, 22'h100);
        plan_fill(10, NPIX - 1, 1'b0);
        plan[10].serr = 1'b1;
        panel_frame(-1, -1, 1'b0);
        plan_run(0, NPIX - 1, 22'h2000);
        panel_frame(-1, -1, 1'b0);
        check("esof_uf_cnt", 32'(underflow_cnt), 32'(0));

        // Backpressure: DE low with source valid fills exactly DEPTH entries.
        reset_dut();
        load_words(22'h3000, 0, NPIX - 1, 1'b0);
        acc_cnt = 0;
        repeat (30) step(1'b0, 1'b1, 1'b0, r);
        check("full_accepts", 32'(acc_cnt), 32'(DEPTH));
        check("full_ready", 32'(r), 32'(0));
        plan_run(0, NPIX - 1, 22'h3000);
        panel_frame(-1, -1, 1'b1);

        // Asynchronous reset at pixel 20, then relock past leftover non-SOF words.
        reset_dut();
        load_words(22'h700, 0, NPIX - 1, 1'b0);
        plan_run(0, NPIX - 1, 22'h700);
        panel_frame(20, -1, 1'b0);
        @(negedge clk);
        #2;
        mon_en   = 1'b0;
        de_in    = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        s_valid  = 1'b0;
        rst      = 1'b1;
        #1;
        check("arst_de", 32'(de_out), 32'(0));
        check("arst_sync", 32'({hsync_out, vsync_out}), 32'(2'b11));
        check("arst_pix", 32'(pix_out), 32'(FILL));
        check("arst_flags", 32'({underflow, sync_err}), 32'(0));
        check("arst_cnt", 32'(underflow_cnt), 32'(0));
        check("arst_ready", 32'(s_ready), 32'(0));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rel_ready_low", 32'(s_ready), 32'(0));
        @(posedge clk);
        #1;
        check("rel_ready_high", 32'(s_ready), 32'(1));
        sb_q.delete();
        src_q.delete();
        load_junk(22'h580, 5, 1'b0);
        load_words(22'h4000, 0, NPIX - 1, 1'b0);
        mon_en = 1'b1;
        plan_run(0, NPIX - 1, 22'h4000);
        panel_frame(-1, -1, 1'b0);
        step(1'b0, 1'b1, 1'b1, r);
        step(1'b0, 1'b1, 1'b1, r);
        check("sb_drain", 32'(sb_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
